// File: rtl/mac_mul_negator_pipe.sv
// Two-stage sign-magnitude front end for the MAC multiplier array: groups lanes into
// 1..NUM_LANES-lane words, converts signed words to magnitudes and emits product-sign flags.
module mac_mul_negator_pipe #(
    parameter  int NUM_LANES  = 4,
    parameter  int LANE_WIDTH = 8,
    localparam int LOG2_LANES = $clog2(NUM_LANES),
    localparam int MODE_W     = $clog2(LOG2_LANES + 1),
    localparam int DW         = NUM_LANES * LANE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MODE_W-1:0]    mode_in,
    input  logic                 signed_in,
    input  logic [DW-1:0]        a_in,
    input  logic [DW-1:0]        b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        a_out,
    output logic [DW-1:0]        b_out,
    output logic [NUM_LANES-1:0] c_neg,
    output logic [MODE_W-1:0]    mode_out
);

    localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(LOG2_LANES);

    logic                 r_s1_valid;
    logic [DW-1:0]        r_s1_a;
    logic [DW-1:0]        r_s1_b;
    logic [MODE_W-1:0]    r_s1_mode;
    logic                 r_s1_signed;
    logic [NUM_LANES-1:0] r_s1_zeroA;
    logic [NUM_LANES-1:0] r_s1_zeroB;
    logic [NUM_LANES-1:0] r_s1_signA;
    logic [NUM_LANES-1:0] r_s1_signB;

    logic                 r_s2_valid;
    logic [DW-1:0]        r_s2_a;
    logic [DW-1:0]        r_s2_b;
    logic [NUM_LANES-1:0] r_s2_cneg;
    logic [MODE_W-1:0]    r_s2_mode;

    logic                 w_s1Load;
    logic                 w_s2Load;
    logic                 w_accept;
    logic [MODE_W-1:0]    w_modeNorm;
    logic [NUM_LANES-1:0] w_zeroA;
    logic [NUM_LANES-1:0] w_zeroB;
    logic [NUM_LANES-1:0] w_signA;
    logic [NUM_LANES-1:0] w_signB;
    logic [NUM_LANES-1:0] w_firstLane;
    logic [NUM_LANES-1:0] w_negA;
    logic [NUM_LANES-1:0] w_negB;
    logic [DW-1:0]        w_magA;
    logic [DW-1:0]        w_magB;
    logic [NUM_LANES-1:0] w_cneg;

    // The borrow restarts at each group's lowest lane and ripples only through all-zero lanes.
    function automatic logic [DW-1:0] toMagnitude(
        input logic [DW-1:0]        data,
        input logic [NUM_LANES-1:0] zero,
        input logic [NUM_LANES-1:0] neg,
        input logic [NUM_LANES-1:0] first
    );
        logic                  chain;
        logic                  cin;
        logic [LANE_WIDTH-1:0] lane;
        toMagnitude = data;
        chain       = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cin   = first[i] | chain;
            chain = cin & zero[i];
            lane  = data[i*LANE_WIDTH +: LANE_WIDTH];
            if (neg[i]) begin
                toMagnitude[i*LANE_WIDTH +: LANE_WIDTH] = ~lane + {{(LANE_WIDTH-1){1'b0}}, cin};
            end
        end
    endfunction

    assign w_s2Load   = ~r_s2_valid | out_ready;
    assign w_s1Load   = ~r_s1_valid | w_s2Load;
    assign in_ready   = w_s1Load & ~flush;
    assign w_accept   = in_valid & in_ready;
    assign w_modeNorm = (mode_in > MAX_MODE) ? '0 : mode_in;

    always_comb begin
        w_zeroA = '0;
        w_zeroB = '0;
        w_signA = '0;
        w_signB = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_zeroA[i] = (a_in[i*LANE_WIDTH +: LANE_WIDTH] == '0);
            w_zeroB[i] = (b_in[i*LANE_WIDTH +: LANE_WIDTH] == '0);
            for (int m = 0; m <= LOG2_LANES; m++) begin
                if (w_modeNorm == MODE_W'(m)) begin
                    w_signA[i] = a_in[(i | ((1 << m) - 1)) * LANE_WIDTH + LANE_WIDTH - 1];
                    w_signB[i] = b_in[(i | ((1 << m) - 1)) * LANE_WIDTH + LANE_WIDTH - 1];
                end
            end
        end
    end

    always_comb begin
        w_firstLane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int m = 0; m <= LOG2_LANES; m++) begin
                if (r_s1_mode == MODE_W'(m)) begin
                    w_firstLane[i] = ((i & ((1 << m) - 1)) == 0);
                end
            end
        end
    end

    assign w_negA = r_s1_signA & {NUM_LANES{r_s1_signed}};
    assign w_negB = r_s1_signB & {NUM_LANES{r_s1_signed}};
    assign w_magA = toMagnitude(r_s1_a, r_s1_zeroA, w_negA, w_firstLane);
    assign w_magB = toMagnitude(r_s1_b, r_s1_zeroB, w_negB, w_firstLane);
    assign w_cneg = r_s1_signed ? (r_s1_signA ^ r_s1_signB) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_mode   <= '0;
            r_s1_signed <= 1'b0;
            r_s1_zeroA  <= '0;
            r_s1_zeroB  <= '0;
            r_s1_signA  <= '0;
            r_s1_signB  <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1Load) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_a      <= a_in;
                r_s1_b      <= b_in;
                r_s1_mode   <= w_modeNorm;
                r_s1_signed <= signed_in;
                r_s1_zeroA  <= w_zeroA;
                r_s1_zeroB  <= w_zeroB;
                r_s1_signA  <= w_signA;
                r_s1_signB  <= w_signB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
            r_s2_cneg  <= '0;
            r_s2_mode  <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2Load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_a    <= w_magA;
                r_s2_b    <= w_magB;
                r_s2_cneg <= w_cneg;
                r_s2_mode <= r_s1_mode;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign a_out     = r_s2_a;
    assign b_out     = r_s2_b;
    assign c_neg     = r_s2_cneg;
    assign mode_out  = r_s2_mode;

endmodule

// File: tb/tb_mac_mul_negator_pipe.sv
// Scoreboard bench for mac_mul_negator_pipe: directed vectors with hand-computed magnitudes,
// expected beats queued at acceptance and popped by an independent output monitor.
module tb_mac_mul_negator_pipe;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int MW = 2;

    typedef struct {
        logic [MW-1:0] mode;
        logic          sgn;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic [NL-1:0] ec;
        logic [MW-1:0] em;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] mode_in = '0;
    logic          signed_in = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [NL-1:0] c_neg;
    logic [MW-1:0] mode_out;

    int   checks = 0;
    int   failures = 0;
    int   cycleCnt = 0;
    int   lastAccept = 0;
    int   outCycles[$];
    vec_t expQ[$];
    vec_t vecs[8];

    mac_mul_negator_pipe #(.NUM_LANES(NL), .LANE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode_in(mode_in), .signed_in(signed_in),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .c_neg(c_neg), .mode_out(mode_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic vec_t mk(input logic [MW-1:0] m, input logic s,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                                input logic [NL-1:0] ec, input logic [MW-1:0] em);
        vec_t v;
        v.mode = m; v.sgn = s; v.a = a; v.b = b;
        v.ea = ea; v.eb = eb; v.ec = ec; v.em = em;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Monitor: every transferred output beat is matched against the oldest queued expectation.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n && out_valid && out_ready) begin
            outCycles.push_back(cycleCnt);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("a_out", a_out, e.ea);
                checkOutput("b_out", b_out, e.eb);
                checkOutput("c_neg", 32'(c_neg), 32'(e.ec));
                checkOutput("mode_out", 32'(mode_out), 32'(e.em));
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic applyStimulus(input int idx);
        vec_t v;
        bit   accepted;
        v = vecs[idx];
        accepted = 1'b0;
        mode_in = v.mode; signed_in = v.sgn; a_in = v.a; b_in = v.b; in_valid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            #1;
            accepted = in_ready;
            @(posedge clk);
            if (accepted) begin
                expQ.push_back(v);
                #1 lastAccept = cycleCnt;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = mk(2'd0, 1'b1, 32'h80FF017F, 32'h00000000, 32'h8001017F, 32'h00000000, 4'b1100, 2'd0);
        vecs[1] = mk(2'd2, 1'b1, 32'hFFFFFF00, 32'h00000003, 32'h00000100, 32'h00000003, 4'b1111, 2'd2);
        vecs[2] = mk(2'd2, 1'b1, 32'hFF000000, 32'h80000000, 32'h01000000, 32'h80000000, 4'b0000, 2'd2);
        vecs[3] = mk(2'd1, 1'b1, 32'hFFFF0000, 32'h0001FFFF, 32'h00010000, 32'h00010001, 4'b1111, 2'd1);
        vecs[4] = mk(2'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 4'b0000, 2'd0);
        vecs[5] = mk(2'd2, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0000, 2'd2);
        vecs[6] = mk(2'd3, 1'b1, 32'h01FF0280, 32'hFF010101, 32'h01010280, 32'h01010101, 4'b1101, 2'd0);
        vecs[7] = mk(2'd1, 1'b1, 32'h0000FFFE, 32'hFFFE0001, 32'h00000002, 32'h00020001, 4'b1111, 2'd1);

        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_a_out", a_out, 32'd0);
        checkOutput("rst_b_out", b_out, 32'd0);
        checkOutput("rst_c_neg", 32'(c_neg), 32'd0);
        checkOutput("rst_mode_out", 32'(mode_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Beat sampled at edge N is registered by edges N and N+1: visible two edges from acceptance.
        outCycles.delete();
        applyStimulus(0);
        waitDrain();
        if (outCycles.size() > 0) checkOutput("latency_edges", 32'(outCycles[0] - lastAccept + 1), 32'd2);
        else checkOutput("latency_no_output", 32'(outCycles.size()), 32'd1);

        for (int i = 1; i < 8; i++) applyStimulus(i);
        waitDrain();

        // Single -> quad -> dual back to back, full throughput.
        outCycles.delete();
        applyStimulus(0);
        applyStimulus(1);
        applyStimulus(3);
        waitDrain();
        checkOutput("b2b_count", 32'(outCycles.size()), 32'd3);
        if (outCycles.size() == 3) begin
            checkOutput("b2b_gap0", 32'(outCycles[1] - outCycles[0]), 32'd1);
            checkOutput("b2b_gap1", 32'(outCycles[2] - outCycles[1]), 32'd1);
        end

        // Backpressure: downstream stalls for 4 edges while three beats are offered.
        outCycles.delete();
        out_ready = 1'b0;
        applyStimulus(4);
        applyStimulus(5);
        mode_in = vecs[6].mode; signed_in = vecs[6].sgn; a_in = vecs[6].a; b_in = vecs[6].b;
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_a", a_out, vecs[4].ea);
            checkOutput("bp_hold_b", b_out, vecs[4].eb);
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(6);
        waitDrain();
        checkOutput("bp_count", 32'(outCycles.size()), 32'd3);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        applyStimulus(0);
        applyStimulus(1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_a_out", a_out, 32'd0);
        expQ.delete();
        outCycles.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 checkOutput("arst_no_emit", 32'(out_valid), 32'd0);
        end
        checkOutput("arst_emitted", 32'(outCycles.size()), 32'd0);
        @(negedge clk);

        // Synchronous flush with two beats in flight and a beat offered in the flush cycle.
        out_ready = 1'b0;
        applyStimulus(2);
        applyStimulus(3);
        flush = 1'b1;
        mode_in = vecs[7].mode; signed_in = vecs[7].sgn; a_in = vecs[7].a; b_in = vecs[7].b;
        in_valid = 1'b1;
        #1 checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1 checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        expQ.delete();
        outCycles.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 checkOutput("flush_no_emit", 32'(out_valid), 32'd0);
        end
        checkOutput("flush_emitted", 32'(outCycles.size()), 32'd0);
        @(negedge clk);

        applyStimulus(7);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
